// File: rtl/bist_controller.sv
// Logic BIST engine: LFSR pattern generator, MISR response compactor and signature compare,
// with a functional-mode bypass of the system primary inputs to the CUT.
module bist_controller #(
    parameter int unsigned       PI_W         = 35,
    parameter int unsigned       PO_W         = 49,
    parameter int unsigned       NUM_PATTERNS = 2000,
    parameter logic [PI_W-1:0]   TPG_TAPS     = 35'h5_0000_0000,
    parameter logic [PI_W-1:0]   TPG_SEED     = 35'h0_0000_0001,
    parameter logic [PO_W-1:0]   MISR_TAPS    = 49'h1_8000_0000_0201,
    parameter logic [PO_W-1:0]   GOLDEN_SIG   = 49'h0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_bistmode,
    input  logic [PI_W-1:0] i_sys_pi,
    input  logic [PO_W-1:0] i_cut_po,
    output logic [PI_W-1:0] o_cut_pi,
    output logic            o_cut_init,
    output logic [PO_W-1:0] o_signature,
    output logic            o_bistdone,
    output logic            o_bistpass
);

    localparam int unsigned     CntW    = $clog2(NUM_PATTERNS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {StIdle, StInit, StRun, StCompare, StDone} state_e;

    state_e          r_state, w_state_d;
    logic [PI_W-1:0] r_lfsr, w_lfsr_d;
    logic [PO_W-1:0] r_misr, w_misr_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_pass, w_pass_d;
    logic            r_bistdone, r_bistpass;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_lfsr     <= TPG_SEED;
            r_misr     <= '0;
            r_cnt      <= '0;
            r_pass     <= 1'b0;
            r_bistdone <= 1'b0;
            r_bistpass <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_lfsr     <= w_lfsr_d;
            r_misr     <= w_misr_d;
            r_cnt      <= w_cnt_d;
            r_pass     <= w_pass_d;
            // Flopped decodes of the next state keep the chip pins glitch-free.
            r_bistdone <= (w_state_d == StDone);
            r_bistpass <= (w_state_d == StDone) && w_pass_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_lfsr_d  = r_lfsr;
        w_misr_d  = r_misr;
        w_cnt_d   = r_cnt;
        w_pass_d  = r_pass;
        unique case (r_state)
            StIdle: begin
                if (i_bistmode) w_state_d = StInit;
            end
            StInit: begin
                if (!i_bistmode) begin
                    w_state_d = StIdle;
                end else begin
                    w_lfsr_d  = TPG_SEED;
                    w_misr_d  = '0;
                    w_cnt_d   = '0;
                    w_pass_d  = 1'b0;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                // An abort leaves the partial signature untouched for debug.
                if (!i_bistmode) begin
                    w_state_d = StIdle;
                end else begin
                    w_lfsr_d = {r_lfsr[PI_W-2:0], ^(r_lfsr & TPG_TAPS)};
                    w_misr_d = {r_misr[PO_W-2:0], ^(r_misr & MISR_TAPS)} ^ i_cut_po;
                    w_cnt_d  = r_cnt + CntW'(1);
                    if (r_cnt == CntLast) w_state_d = StCompare;
                end
            end
            StCompare: begin
                if (!i_bistmode) begin
                    w_state_d = StIdle;
                end else begin
                    w_pass_d  = (r_misr == GOLDEN_SIG);
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (!i_bistmode) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_cut_pi    = (r_state == StInit || r_state == StRun) ? r_lfsr : i_sys_pi;
    assign o_cut_init  = (r_state == StInit);
    assign o_signature = r_misr;
    assign o_bistdone  = r_bistdone;
    assign o_bistpass  = r_bistpass;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: a default-width instance and a small 4-bit instance, both checked
// against a pattern/signature model computed from the LFSR and MISR recurrences.
module tb_bist_controller;

    localparam int          BN    = 2000;
    localparam logic [63:0] BTAPS = 64'h5_0000_0000;
    localparam logic [63:0] BSEED = 64'h1;
    localparam logic [63:0] BMT   = 64'h1_8000_0000_0201;
    localparam int          SN    = 15;
    localparam logic [63:0] STAPS = 64'h9;
    localparam logic [63:0] SMT   = 64'hB8;

    logic        clk, rst_n;
    logic        b_mode, b_init, b_done, b_pass;
    logic [34:0] b_sys, b_cut_pi;
    logic [48:0] b_po, b_sig;
    logic        s_mode, s_init, s_done, s_pass;
    logic [3:0]  s_sys, s_cut_pi;
    logic [7:0]  s_po, s_sig;

    int errors = 0;
    int checks = 0;

    bist_controller u_big (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_bistmode  (b_mode),
        .i_sys_pi    (b_sys),
        .i_cut_po    (b_po),
        .o_cut_pi    (b_cut_pi),
        .o_cut_init  (b_init),
        .o_signature (b_sig),
        .o_bistdone  (b_done),
        .o_bistpass  (b_pass)
    );

    bist_controller #(
        .PI_W         (4),
        .PO_W         (8),
        .NUM_PATTERNS (SN),
        .TPG_TAPS     (4'b1001),
        .TPG_SEED     (4'h1),
        .MISR_TAPS    (8'hB8),
        .GOLDEN_SIG   (8'h00)
    ) u_small (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_bistmode  (s_mode),
        .i_sys_pi    (s_sys),
        .i_cut_po    (s_po),
        .o_cut_pi    (s_cut_pi),
        .o_cut_init  (s_init),
        .o_signature (s_sig),
        .o_bistdone  (s_done),
        .o_bistpass  (s_pass)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One shift of a w-bit feedback register, with an optional parallel injection word.
    function automatic logic [63:0] shift_fb(input logic [63:0] v, input logic [63:0] taps,
                                             input int w, input logic [63:0] inj);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (((v << 1) | {63'd0, ^(v & taps)}) ^ inj) & mask;
    endfunction

    // mode: 0 = cut_po tied low, 1 = one bit stuck high, 2 = random responses.
    task automatic big_run(input int mode, input int abort_at, output logic pass_o);
        logic [63:0] lf, ms, po;
        bit          aborted;
        lf = BSEED;
        ms = 64'd0;
        aborted = 1'b0;
        pass_o = 1'b0;
        b_mode = 1'b1;
        step();
        check("big_init_on", 64'(b_init), 64'd1);
        step();
        check("big_init_off", 64'(b_init), 64'd0);
        for (int k = 0; k < BN && !aborted; k++) begin
            if (k == abort_at) begin
                b_mode = 1'b0;
                b_sys = 35'($urandom) ^ {$urandom, 3'b0};
                step();
                check("abort_done", 64'(b_done), 64'd0);
                check("abort_bypass", 64'(b_cut_pi), 64'(b_sys));
                check("abort_sig_held", 64'(b_sig), ms);
                aborted = 1'b1;
            end else begin
                case (mode)
                    0:       po = 64'd0;
                    1:       po = 64'd1 << 7;
                    default: po = {$urandom, $urandom} & ((64'd1 << 49) - 64'd1);
                endcase
                b_po = 49'(po);
                if (k < 3 || k % 397 == 0 || k == BN - 1) check("big_pattern", 64'(b_cut_pi), lf);
                ms = shift_fb(ms, BMT, 49, po);
                lf = shift_fb(lf, BTAPS, 35, 64'd0);
                step();
            end
        end
        b_po = '0;
        if (!aborted) begin
            check("big_done_early", 64'(b_done), 64'd0);
            step();
            check("big_done", 64'(b_done), 64'd1);
            check("big_sig", 64'(b_sig), ms);
            check("big_pass", 64'(b_pass), 64'(ms == 64'd0));
            pass_o = (ms == 64'd0);
        end
    endtask

    task automatic drop_big();
        b_mode = 1'b0;
        step();
        check("drop_done", 64'(b_done), 64'd0);
        check("drop_pass", 64'(b_pass), 64'd0);
    endtask

    initial begin
        logic [63:0] lf, ms, sig_hold;
        logic [3:0]  first_pats [6];
        logic        p0, p1, px;
        bit [15:0]   seen;
        first_pats = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD};

        rst_n = 1'b0;
        b_mode = 1'b0;
        s_mode = 1'b0;
        b_po = '0;
        s_po = '0;
        b_sys = 35'h1_2345_6789;
        s_sys = 4'h6;
        #3;
        check("rst_done", 64'(b_done), 64'd0);
        check("rst_pass", 64'(b_pass), 64'd0);
        check("rst_init", 64'(b_init), 64'd0);
        check("rst_sig", 64'(b_sig), 64'd0);
        check("rst_bypass", 64'(b_cut_pi), 64'(b_sys));
        #20 rst_n = 1'b1;

        b_sys = 35'h5_A5A5_A5A5;
        #1;
        check("func_bypass", 64'(b_cut_pi), 64'h5_A5A5_A5A5);
        check("func_done", 64'(b_done), 64'd0);
        check("func_pass", 64'(b_pass), 64'd0);
        check("func_init", 64'(b_init), 64'd0);

        // Small configuration: pattern sequence, one-cycle init, done after edge SN+3.
        lf = 64'h1;
        ms = 64'd0;
        seen = '0;
        s_mode = 1'b1;
        step();
        check("s_init_on", 64'(s_init), 64'd1);
        step();
        check("s_init_off", 64'(s_init), 64'd0);
        for (int k = 0; k < SN; k++) begin
            s_po = 8'($urandom);
            check("s_pattern", 64'(s_cut_pi), lf);
            if (k < 6) check("s_pattern_tbl", 64'(s_cut_pi), 64'(first_pats[k]));
            seen[s_cut_pi] = 1'b1;
            ms = shift_fb(ms, SMT, 8, 64'(s_po));
            lf = shift_fb(lf, STAPS, 4, 64'd0);
            if (k != 0) check("s_init_low", 64'(s_init), 64'd0);
            step();
        end
        s_po = '0;
        check("s_period", 64'($countones(seen[15:1])), 64'd15);
        check("s_done_edge17", 64'(s_done), 64'd0);
        step();
        check("s_done_edge18", 64'(s_done), 64'd1);
        check("s_sig", 64'(s_sig), ms);
        check("s_pass", 64'(s_pass), 64'(ms == 64'd0));
        s_mode = 1'b0;
        step();
        check("s_drop", 64'(s_done), 64'd0);

        // Default configuration, all-zero responses: golden 0 must pass.
        big_run(0, -1, p0);
        sig_hold = 64'(b_sig);
        repeat (3) step();
        check("done_hold", 64'(b_done), 64'd1);
        check("done_sig_hold", 64'(b_sig), sig_hold);
        drop_big();

        big_run(2, -1, px);
        drop_big();
        big_run(1, -1, px);
        check("stuck_fails", 64'(px), 64'd0);
        drop_big();

        big_run(0, 500, px);
        big_run(0, -1, p1);
        check("rerun_pass_same", 64'(p1), 64'(p0));
        drop_big();

        // Asynchronous reset in the middle of a run.
        b_mode = 1'b1;
        repeat (40) step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_done", 64'(b_done), 64'd0);
        check("mid_rst_sig", 64'(b_sig), 64'd0);
        check("mid_rst_init", 64'(b_init), 64'd0);
        check("mid_rst_bypass", 64'(b_cut_pi), 64'(b_sys));
        #2 rst_n = 1'b1;
        big_run(0, -1, p1);
        check("post_rst_pass", 64'(p1), 64'd1);
        drop_big();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- On-chip BIST engine inside the chip wrapper, sitting between the pins and the sequential CUT (35 PI / 49 PO).
- Functional mode (bistmode=0): passes the system PI straight to the CUT.
- BIST mode: generates pseudo-random patterns with an LFSR, compacts the CUT responses in a MISR, and compares the final signature with a hard-coded golden value.
- Drives the chip-level bistdone/bistpass pins.

Parameters:
- PI_W, 35, CUT primary-input width (LFSR width).
- PO_W, 49, CUT primary-output width (MISR width).
- NUM_PATTERNS, 2000, number of patterns applied and responses compacted (>=1).
- TPG_TAPS, 35'h5_0000_0000, LFSR feedback tap mask (bit i set = lfsr[i] in feedback).
- TPG_SEED, 35'h0_0000_0001, LFSR seed; must be nonzero.
- MISR_TAPS, 49'h1_8000_0000_0201, MISR feedback tap mask.
- GOLDEN_SIG, 49'h0, expected fault-free signature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- bistmode  in  1  1 = run/hold BIST, 0 = functional mode.
- sys_pi  in  PI_W  functional primary inputs from pins.
- cut_po  in  PO_W  CUT primary outputs.
- cut_pi  out  PI_W  CUT primary inputs.
- cut_init  out  1  CUT state initialise; the chip ORs it into the CUT reset.
- signature  out  PO_W  current MISR contents, for debug and golden extraction.
- bistdone  out  1  BIST complete.
- bistpass  out  1  signature matched; valid only while bistdone=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, lfsr=TPG_SEED, misr=0, cnt=0, pass_r=0.
  - Outputs: bistdone=0, bistpass=0, cut_init=0, signature=0.
- cut_pi = lfsr when state is INIT or RUN; otherwise cut_pi = sys_pi (combinational mux).
- States:
  - IDLE: bistmode=1 -> INIT.
  - INIT (1 cycle): cut_init=1; lfsr<=TPG_SEED, misr<=0, cnt<=0, pass_r<=0 -> RUN.
  - RUN: every rising edge does all of the following:
    - lfsr <= {lfsr[PI_W-2:0], ^(lfsr & TPG_TAPS)}.
    - misr <= {misr[PO_W-2:0], ^(misr & MISR_TAPS)} ^ cut_po. This compacts the response to the pattern applied during the preceding cycle.
    - cnt <= cnt+1.
    - When cnt==NUM_PATTERNS-1 -> COMPARE. Exactly NUM_PATTERNS captures occur.
  - COMPARE (1 cycle): pass_r <= (misr==GOLDEN_SIG); lfsr and misr hold -> DONE.
  - DONE: bistdone=1, bistpass=pass_r; all registers hold.
    - bistmode stays 1 -> remain in DONE (no auto-restart).
    - bistmode=0 -> IDLE.
- Latency: counting the edge that samples bistmode=1 in IDLE as edge 1, bistdone rises after edge NUM_PATTERNS+3.
- bistmode=0 in INIT/RUN/COMPARE: abort to IDLE on the next edge; bistdone stays 0 and misr is left as is.
- bistdone and bistpass are registered decodes of state/pass_r, so they are glitch-free.
- Reset mid-run: immediate return to reset values. After release, a new run starts if bistmode=1.
- Counter width: $clog2(NUM_PATTERNS+1); must not wrap before the terminal compare.
- The LFSR never reaches all-zero with a nonzero seed and primitive taps.

Test Plan:
- Small config (PI_W=4, TPG_TAPS=4'b1001, TPG_SEED=4'h1, NUM_PATTERNS=15), bistmode=1 after reset:
  - cut_pi during RUN = 1,3,7,F,E,D,... with period 15.
  - cut_init=1 for exactly one cycle.
  - bistdone rises after edge 18.
- cut_po tied to 0, GOLDEN_SIG=0, default widths -> signature stays 0; bistdone=1 with bistpass=1 after edge 2003.
- Run the default config against the real CUT, read the signature, and set GOLDEN_SIG to it:
  - rerun -> bistpass=1;
  - force one cut_po bit to 1 for the whole run -> bistpass=0, bistdone=1.
- bistmode dropped at RUN cycle 500 -> IDLE next edge, bistdone stays 0, cut_pi==sys_pi; bistmode reasserted -> full fresh run, pass result unchanged.
- rst pulsed low mid-RUN between clock edges -> outputs clear immediately, without waiting for an edge. After release with bistmode=1, bistdone rises NUM_PATTERNS+3 edges later.
- bistmode=0, sys_pi=35'h5_A5A5_A5A5 -> cut_pi equals it in the same cycle; bistdone=0, bistpass=0, cut_init=0.
